// File: rtl/sd_spi_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_spi_responder_if
// Purpose  : SPI link plus backing-RAM port bundle for the SD SPI responder.
//            The "slave" modport is the card side; the "master" modport is
//            the environment side (SPI host and the synchronous byte RAM).
// Signals  : cs (active-low), sclk, mosi, miso,
//            mem_addr, mem_rdata, mem_wdata, mem_we
// Revision : 1.0  initial release
// ============================================================================
interface sd_spi_responder_if #(
   parameter int ADDR_W = 16
);
   logic              cs;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [7:0]        mem_wdata;
   logic              mem_we;

   modport master (
      output cs, sclk, mosi, mem_rdata,
      input  miso, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      input  cs, sclk, mosi, mem_rdata,
      output miso, mem_addr, mem_wdata, mem_we
   );
endinterface
`default_nettype wire

// File: rtl/sd_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : sd_spi_responder
// Purpose  : SPI-mode SD card emulator backed by a synchronous byte RAM.
//            Decodes 48-bit command frames, answers with R1, serves CMD17
//            single-block reads and accepts CMD24 single-block writes.
// Ports    : clk, rst (async, active-high)
//            bus        - SPI pins and RAM port (slave modport)
//            card_idle  - R1 idle bit
//            state_dbg  - current FSM state encoding
// Revision : 1.0  initial release
// ============================================================================
module sd_spi_responder #(
   parameter int ADDR_W         = 16,
   parameter int ACMD41_RETRIES = 2,
   parameter int BUSY_BYTES     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   sd_spi_responder_if.slave    bus,
   output logic                 card_idle,
   output logic [3:0]           state_dbg
);
   localparam int         BLK_W          = ADDR_W - 9;
   localparam logic [7:0] c_acmd_retries = 8'(ACMD41_RETRIES);
   localparam logic [7:0] c_busy_last    = 8'(BUSY_BYTES - 1);

   typedef enum logic [3:0] {
      ST_WAIT_CMD      = 4'd0,
      ST_RX_CMD        = 4'd1,
      ST_NCR           = 4'd2,
      ST_SEND_R1       = 4'd3,
      ST_RD_TOKEN      = 4'd4,
      ST_RD_DATA       = 4'd5,
      ST_RD_CRC        = 4'd6,
      ST_WR_WAIT_TOKEN = 4'd7,
      ST_WR_DATA       = 4'd8,
      ST_WR_CRC        = 4'd9,
      ST_WR_RESP       = 4'd10,
      ST_WR_BUSY       = 4'd11
   } state_t;

   // Synchronisers; sclk carries one extra stage for edge detection.
   logic [1:0] r_cs_sync;
   logic [2:0] r_sclk_sync;
   logic [1:0] r_mosi_sync;

   state_t             r_state;
   logic [2:0]         r_bit_cnt;
   logic [6:0]         r_rx_shift;
   logic [6:0]         r_tx_shift;     // bits still to be shifted out
   logic [7:0]         r_tx_next;      // byte for the next slot
   logic               r_tx_src_mem;   // next slot takes mem_rdata instead
   logic               r_load_pending;
   logic               r_miso;
   logic [5:0]         r_cmd;
   logic [BLK_W-1:0]   r_blk;
   logic [7:0]         r_r1;
   logic               r_data_ok;
   logic [7:0]         r_cnt;
   logic [8:0]         r_idx;
   logic [15:0]        r_crc;
   logic               r_card_idle;
   logic               r_app_cmd;
   logic [7:0]         r_acmd_cnt;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [7:0]         r_mem_wdata;
   logic               r_mem_we;

   logic       w_cs_high;
   logic       w_sclk_rise;
   logic       w_sclk_fall;
   logic [7:0] w_rx_byte;
   logic [7:0] w_load_byte;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                              input logic [7:0]  data);
      logic [15:0] c;
      c = crc_in;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   assign w_cs_high   = r_cs_sync[1];
   assign w_sclk_rise =  r_sclk_sync[1] & ~r_sclk_sync[2];
   assign w_sclk_fall = ~r_sclk_sync[1] &  r_sclk_sync[2];
   assign w_rx_byte   = {r_rx_shift, r_mosi_sync[1]};
   assign w_load_byte = r_tx_src_mem ? bus.mem_rdata : r_tx_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cs_sync   <= 2'b11;
         r_sclk_sync <= 3'b000;
         r_mosi_sync <= 2'b11;
      end else begin
         r_cs_sync   <= {r_cs_sync[0], bus.cs};
         r_sclk_sync <= {r_sclk_sync[1:0], bus.sclk};
         r_mosi_sync <= {r_mosi_sync[0], bus.mosi};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_WAIT_CMD;
         r_bit_cnt      <= 3'd0;
         r_rx_shift     <= 7'd0;
         r_tx_shift     <= 7'h7F;
         r_tx_next      <= 8'hFF;
         r_tx_src_mem   <= 1'b0;
         r_load_pending <= 1'b0;
         r_miso         <= 1'b1;
         r_cmd          <= 6'd0;
         r_blk          <= '0;
         r_r1           <= 8'hFF;
         r_data_ok      <= 1'b0;
         r_cnt          <= 8'd0;
         r_idx          <= 9'd0;
         r_crc          <= 16'h0000;
         r_card_idle    <= 1'b1;
         r_app_cmd      <= 1'b0;
         r_acmd_cnt     <= 8'd0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= 8'd0;
         r_mem_we       <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         if (w_cs_high) begin
            // Deselect drops the transaction; card-level state is retained.
            r_state        <= ST_WAIT_CMD;
            r_bit_cnt      <= 3'd0;
            r_tx_shift     <= 7'h7F;
            r_tx_next      <= 8'hFF;
            r_tx_src_mem   <= 1'b0;
            r_load_pending <= 1'b0;
            r_miso         <= 1'b1;
         end else begin
            if (w_sclk_fall) begin
               if (r_load_pending) begin
                  r_load_pending <= 1'b0;
                  r_miso         <= w_load_byte[7];
                  r_tx_shift     <= w_load_byte[6:0];
                  if (r_tx_src_mem) r_crc <= crc16_byte(r_crc, bus.mem_rdata);
               end else begin
                  r_miso     <= r_tx_shift[6];
                  r_tx_shift <= {r_tx_shift[5:0], 1'b1};
               end
            end
            if (w_sclk_rise) begin
               r_rx_shift <= w_rx_byte[6:0];
               r_bit_cnt  <= r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  // Byte complete: choose what goes out in the following slot.
                  r_load_pending <= 1'b1;
                  r_tx_next      <= 8'hFF;
                  r_tx_src_mem   <= 1'b0;
                  case (r_state)
                     ST_WAIT_CMD: begin
                        if (w_rx_byte[7:6] == 2'b01) begin
                           r_cmd   <= w_rx_byte[5:0];
                           r_cnt   <= 8'd0;
                           r_state <= ST_RX_CMD;
                        end
                     end
                     ST_RX_CMD: begin
                        if (r_cnt == 8'd4) begin
                           // CRC7 byte: discard it and decode the command.
                           r_state   <= ST_NCR;
                           r_data_ok <= 1'b0;
                           r_app_cmd <= (r_cmd == 6'd55);
                           if (r_cmd == 6'd0) begin
                              r_card_idle <= 1'b1;
                              r_acmd_cnt  <= 8'd0;
                              r_r1        <= 8'h01;
                           end else if (r_cmd == 6'd55) begin
                              r_r1 <= {7'd0, r_card_idle};
                           end else if (r_cmd == 6'd41 && r_app_cmd) begin
                              if (r_acmd_cnt < c_acmd_retries) begin
                                 r_acmd_cnt <= r_acmd_cnt + 8'd1;
                                 r_r1       <= 8'h01;
                              end else begin
                                 r_card_idle <= 1'b0;
                                 r_r1        <= 8'h00;
                              end
                           end else if (r_cmd == 6'd16) begin
                              r_r1 <= {7'd0, r_card_idle};
                           end else if (r_cmd == 6'd17 || r_cmd == 6'd24) begin
                              if (r_card_idle) begin
                                 r_r1 <= 8'h05;
                              end else begin
                                 r_r1      <= 8'h00;
                                 r_data_ok <= 1'b1;
                              end
                           end else begin
                              r_r1 <= 8'h04 | {7'd0, r_card_idle};
                           end
                        end else begin
                           // Only the low block-number bits survive; upper
                           // argument bits fall off, so block numbers wrap.
                           r_blk <= BLK_W'({r_blk, w_rx_byte});
                           r_cnt <= r_cnt + 8'd1;
                        end
                     end
                     ST_NCR: begin
                        r_tx_next <= r_r1;
                        r_state   <= ST_SEND_R1;
                     end
                     ST_SEND_R1: begin
                        if (r_data_ok && r_cmd == 6'd17) begin
                           r_tx_next  <= 8'hFE;
                           r_idx      <= 9'd0;
                           r_mem_addr <= {r_blk, 9'd0};
                           r_crc      <= 16'h0000;
                           r_state    <= ST_RD_TOKEN;
                        end else if (r_data_ok && r_cmd == 6'd24) begin
                           r_state <= ST_WR_WAIT_TOKEN;
                        end else begin
                           r_state <= ST_WAIT_CMD;
                        end
                     end
                     ST_RD_TOKEN: begin
                        r_tx_src_mem <= 1'b1;
                        r_state      <= ST_RD_DATA;
                     end
                     ST_RD_DATA: begin
                        if (r_idx == 9'd511) begin
                           r_tx_next <= r_crc[15:8];
                           r_cnt     <= 8'd0;
                           r_state   <= ST_RD_CRC;
                        end else begin
                           // Address moves at the rise; the byte is taken at
                           // the next fall, several clk later.
                           r_idx        <= r_idx + 9'd1;
                           r_mem_addr   <= {r_blk, r_idx + 9'd1};
                           r_tx_src_mem <= 1'b1;
                        end
                     end
                     ST_RD_CRC: begin
                        if (r_cnt == 8'd0) begin
                           r_tx_next <= r_crc[7:0];
                           r_cnt     <= 8'd1;
                        end else begin
                           r_state <= ST_WAIT_CMD;
                        end
                     end
                     ST_WR_WAIT_TOKEN: begin
                        if (w_rx_byte == 8'hFE) begin
                           r_idx   <= 9'd0;
                           r_state <= ST_WR_DATA;
                        end else if (w_rx_byte != 8'hFF) begin
                           r_state <= ST_WAIT_CMD;
                        end
                     end
                     ST_WR_DATA: begin
                        r_mem_addr  <= {r_blk, r_idx};
                        r_mem_wdata <= w_rx_byte;
                        r_mem_we    <= 1'b1;
                        if (r_idx == 9'd511) begin
                           r_cnt   <= 8'd0;
                           r_state <= ST_WR_CRC;
                        end else begin
                           r_idx <= r_idx + 9'd1;
                        end
                     end
                     ST_WR_CRC: begin
                        if (r_cnt == 8'd1) begin
                           r_tx_next <= 8'h05;
                           r_state   <= ST_WR_RESP;
                        end else begin
                           r_cnt <= 8'd1;
                        end
                     end
                     ST_WR_RESP: begin
                        r_tx_next <= 8'h00;
                        r_cnt     <= 8'd0;
                        r_state   <= ST_WR_BUSY;
                     end
                     ST_WR_BUSY: begin
                        if (r_cnt == c_busy_last) begin
                           r_state <= ST_WAIT_CMD;
                        end else begin
                           r_tx_next <= 8'h00;
                           r_cnt     <= r_cnt + 8'd1;
                        end
                     end
                     default: r_state <= ST_WAIT_CMD;
                  endcase
               end
            end
         end
      end
   end

   assign bus.miso      = r_miso;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_we    = r_mem_we;
   assign card_idle     = r_card_idle;
   assign state_dbg     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_spi_responder
// Purpose  : Self-checking bench for sd_spi_responder: an SPI host model,
//            a synchronous byte RAM model and scoreboards for miso bytes and
//            RAM writes.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_spi_responder;
   localparam int ADDR_W = 16;

   typedef struct {
      logic [5:0]  cmd;
      logic [31:0] arg;
      logic [7:0]  r1;
      logic        idle;
   } cmd_vec_t;

   typedef struct {
      logic [7:0] val;
      string      tag;
   } exp_byte_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } wr_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       card_idle;
   logic [3:0] state_dbg;
   logic [7:0] ram [0:(1<<ADDR_W)-1];

   int errors = 0;
   int checks = 0;

   exp_byte_t exp_q[$];
   wr_t       exp_wr_q[$];
   wr_t       obs_wr_q[$];
   cmd_vec_t  vecs[18];

   sd_spi_responder_if #(.ADDR_W(ADDR_W)) bus();

   sd_spi_responder #(
      .ADDR_W(ADDR_W), .ACMD41_RETRIES(2), .BUSY_BYTES(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .card_idle(card_idle), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // Byte RAM: block 2 preloaded with i & 0xFF while reset is held.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 512; i++) ram[16'h0400 + i] <= 8'(i);
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   always @(negedge clk) begin
      if (bus.mem_we) obs_wr_q.push_back({bus.mem_addr, bus.mem_wdata});
   end

   function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      repeat (8) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One SPI mode-0 byte; sclk low 50 ns, high 30 ns (8 clk per bit).
   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         bus.mosi = tx[i];
         #50;
         rx[i] = bus.miso;
         bus.sclk = 1'b1;
         #30;
         bus.sclk = 1'b0;
      end
   endtask

   task automatic chk_byte(input logic [7:0] tx, input logic [7:0] exp, input string tag);
      exp_byte_t  e;
      logic [7:0] rx;
      exp_q.push_back('{val: exp, tag: tag});
      xfer(tx, rx);
      e = exp_q.pop_front();
      check(e.tag, {24'd0, rx}, {24'd0, e.val});
   endtask

   task automatic send_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic [7:0] r1);
      chk_byte({2'b01, cmd}, 8'hFF, "frame");
      for (int b = 3; b >= 0; b--) chk_byte(arg[8*b +: 8], 8'hFF, "frame");
      chk_byte((cmd == 6'd0) ? 8'h95 : 8'h01, 8'hFF, "frame_crc");
      chk_byte(8'hFF, 8'hFF, "ncr");
      chk_byte(8'hFF, r1, $sformatf("r1_cmd%0d", cmd));
   endtask

   task automatic check_writes(input string tag);
      wr_t e, o;
      check({tag, "_count"}, obs_wr_q.size(), exp_wr_q.size());
      while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
         e = exp_wr_q.pop_front();
         o = obs_wr_q.pop_front();
         check(tag, o, e);
      end
      exp_wr_q.delete();
      obs_wr_q.delete();
   endtask

   initial begin
      logic [15:0] crc;
      vecs[0]  = '{6'd0,  32'h0,   8'h01, 1'b1};
      vecs[1]  = '{6'd17, 32'h2,   8'h05, 1'b1};
      vecs[2]  = '{6'd24, 32'h3,   8'h05, 1'b1};
      vecs[3]  = '{6'd58, 32'h0,   8'h05, 1'b1};
      vecs[4]  = '{6'd18, 32'h0,   8'h05, 1'b1};
      vecs[5]  = '{6'd16, 32'h200, 8'h01, 1'b1};
      vecs[6]  = '{6'd41, 32'h0,   8'h05, 1'b1};
      vecs[7]  = '{6'd55, 32'h0,   8'h01, 1'b1};
      vecs[8]  = '{6'd41, 32'h0,   8'h01, 1'b1};
      vecs[9]  = '{6'd55, 32'h0,   8'h01, 1'b1};
      vecs[10] = '{6'd41, 32'h0,   8'h01, 1'b1};
      vecs[11] = '{6'd55, 32'h0,   8'h01, 1'b1};
      vecs[12] = '{6'd41, 32'h0,   8'h00, 1'b0};
      vecs[13] = '{6'd58, 32'h0,   8'h04, 1'b0};
      vecs[14] = '{6'd16, 32'h200, 8'h00, 1'b0};
      vecs[15] = '{6'd25, 32'h0,   8'h04, 1'b0};
      vecs[16] = '{6'd55, 32'h0,   8'h00, 1'b0};
      vecs[17] = '{6'd8,  32'h1AA, 8'h04, 1'b0};

      rst = 1'b1;
      bus.cs = 1'b1;
      bus.sclk = 1'b0;
      bus.mosi = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_miso", bus.miso, 1);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_card_idle", card_idle, 1);
      check("rst_state", state_dbg, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      bus.cs = 1'b0;
      repeat (4) @(posedge clk);
      #3;

      // Command/R1 table: init sequence, illegal commands, idle rejections.
      for (int v = 0; v < 18; v++) begin
         send_cmd(vecs[v].cmd, vecs[v].arg, vecs[v].r1);
         check($sformatf("idle_after_row%0d", v), card_idle, vecs[v].idle);
         chk_byte(8'hFF, 8'hFF, $sformatf("no_token_row%0d", v));
      end

      // CMD17 from block 2.
      send_cmd(6'd17, 32'h2, 8'h00);
      chk_byte(8'hFF, 8'hFE, "rd_token");
      crc = 16'h0000;
      for (int i = 0; i < 512; i++) begin
         chk_byte(8'hFF, 8'(i), "rd_data");
         crc = crc_model(crc, 8'(i));
      end
      chk_byte(8'hFF, crc[15:8], "rd_crc_hi");
      chk_byte(8'hFF, crc[7:0], "rd_crc_lo");
      chk_byte(8'hFF, 8'hFF, "rd_idle");

      // CMD24 to block 3, with a few idle bytes before the token.
      send_cmd(6'd24, 32'h3, 8'h00);
      chk_byte(8'hFF, 8'hFF, "wr_gap");
      chk_byte(8'hFF, 8'hFF, "wr_gap");
      chk_byte(8'hFE, 8'hFF, "wr_token");
      for (int i = 0; i < 512; i++) begin
         exp_wr_q.push_back({16'h0600 + 16'(i), 8'hA5});
         chk_byte(8'hA5, 8'hFF, "wr_data_miso");
      end
      chk_byte(8'hFF, 8'hFF, "wr_crc");
      chk_byte(8'hFF, 8'hFF, "wr_crc");
      chk_byte(8'hFF, 8'h05, "wr_resp");
      for (int i = 0; i < 4; i++) chk_byte(8'hFF, 8'h00, "wr_busy");
      chk_byte(8'hFF, 8'hFF, "wr_idle");
      check_writes("wr_full");

      // Bad token aborts; the next frame must decode from WAIT_CMD.
      send_cmd(6'd24, 32'h3, 8'h00);
      chk_byte(8'h12, 8'hFF, "tok_abort");
      send_cmd(6'd16, 32'h200, 8'h00);
      check_writes("wr_tok_abort");

      // Deselect part-way through a write; upper argument bits ignored.
      send_cmd(6'd24, 32'hFF00_0005, 8'h00);
      chk_byte(8'hFE, 8'hFF, "ab_token");
      for (int i = 0; i < 100; i++) begin
         exp_wr_q.push_back({16'h0A00 + 16'(i), 8'(i) ^ 8'h3C});
         chk_byte(8'(i) ^ 8'h3C, 8'hFF, "ab_data_miso");
      end
      bus.cs = 1'b1;
      repeat (10) @(posedge clk);
      #3;
      check("ab_cs_miso", bus.miso, 1);
      check("ab_cs_state", state_dbg, 0);
      bus.cs = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      send_cmd(6'd0, 32'h0, 8'h01);
      check("ab_idle", card_idle, 1);
      check_writes("wr_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
